adc_scan_ctrl: RTL and testbench

- Scan sequencer for the board's LTC2308 8-channel 12-bit SPI ADC (ADC_CONVST/ADC_SCLK/ADC_DIN/ADC_DOUT).
- Round-robins over the channels enabled in a host mask and drives convert/shift frames.
- Resolves the ADC's one-frame config-to-data pipeline and stores the latest result per channel in a local register file.
- Sits between the board ADC pins and the ADC host device register interface.

---
 rtl/adc_ctrl_pkg.sv | 57 +++++
 rtl/adc_ltc2308_frame.sv | 70 +++++++
 rtl/adc_scan_ctrl.sv | 134 +++++++++++++
 tb/tb_adc_scan_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/adc_ctrl_pkg.sv
// Shared types, constants and helpers for the LTC2308 scan controller.
// Channel pick helpers scan the host mask; cfg_word packs the ADC config.
package adc_ctrl_pkg;

    localparam int NUM_CH     = 8;
    localparam int DATA_W     = 12;
    localparam int CH_W       = 3;
    localparam int CFG_BITS   = 6;
    localparam int FRAME_BITS = 12;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        SHIFT,
        UPDATE
    } state_t;

    // S/D=1 (single-ended), O/S, S1, S0, UNI, SLP=0
    function automatic logic [CFG_BITS-1:0] cfg_word(
        input logic [CH_W-1:0] ch,
        input logic            uni
    );
        return {1'b1, ch[0], ch[2], ch[1], uni, 1'b0};
    endfunction

    function automatic logic [CH_W-1:0] low_ch(
        input logic [NUM_CH-1:0] mask
    );
        logic [CH_W-1:0] r;
        r = '0;
        for (int i = NUM_CH - 1; i >= 0; i--)
            if (mask[i]) r = CH_W'(i);
        return r;
    endfunction

    function automatic logic [CH_W-1:0] high_ch(
        input logic [NUM_CH-1:0] mask
    );
        logic [CH_W-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_CH; i++)
            if (mask[i]) r = CH_W'(i);
        return r;
    endfunction

    function automatic logic [CH_W-1:0] next_ch(
        input logic [NUM_CH-1:0] mask,
        input logic [CH_W-1:0]   cur
    );
        logic [CH_W-1:0] r;
        r = low_ch(mask);
        for (int i = NUM_CH - 1; i >= 0; i--)
            if (mask[i] && i > int'(cur)) r = CH_W'(i);
        return r;
    endfunction

endpackage

// File: rtl/adc_ltc2308_frame.sv
// One LTC2308 SPI frame: SCLK divider, config shift-out, data shift-in.
// done is high in the final SHIFT cycle so the caller can step straight on.
module adc_ltc2308_frame
    import adc_ctrl_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [CFG_BITS-1:0]   cfg,
    input  logic                  adc_dout,
    output logic                  adc_sclk,
    output logic                  adc_din,
    output logic [FRAME_BITS-1:0] data,
    output logic                  done
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [3:0] BIT_LAST = 4'(FRAME_BITS - 1);

    logic                  active;
    logic [DW-1:0]         div;
    logic [3:0]            bit_idx;
    logic [FRAME_BITS-1:0] tx;
    logic                  phase_end;

    assign phase_end = active && (div == DIV_LAST);
    assign done = phase_end && adc_sclk && (bit_idx == BIT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            active   <= 1'b0;
            div      <= '0;
            bit_idx  <= '0;
            tx       <= '0;
            adc_sclk <= 1'b0;
            adc_din  <= 1'b0;
            data     <= '0;
        end else if (start) begin
            active   <= 1'b1;
            div      <= '0;
            bit_idx  <= '0;
            adc_sclk <= 1'b0;
            adc_din  <= cfg[CFG_BITS-1];
            tx       <= {cfg[CFG_BITS-2:0], {(FRAME_BITS - CFG_BITS + 1){1'b0}}};
        end else if (active) begin
            div <= phase_end ? '0 : div + 1'b1;
            if (phase_end) begin
                if (!adc_sclk) begin
                    // ADC data is taken on the cycle SCLK rises
                    adc_sclk <= 1'b1;
                    data     <= {data[FRAME_BITS-2:0], adc_dout};
                end else begin
                    adc_sclk <= 1'b0;
                    if (bit_idx == BIT_LAST) begin
                        active  <= 1'b0;
                        adc_din <= 1'b0;
                    end else begin
                        bit_idx <= bit_idx + 1'b1;
                        adc_din <= tx[FRAME_BITS-1];
                        tx      <= {tx[FRAME_BITS-2:0], 1'b0};
                    end
                end
            end
        end
    end

endmodule

// File: rtl/adc_scan_ctrl.sv
// LTC2308 round-robin scan sequencer with per-channel result registers.
// Data from each frame belongs to the channel configured one frame earlier.
module adc_scan_ctrl #(
    parameter int CLK_DIV     = 2,
    parameter int CONV_CYCLES = 80,
    parameter int NUM_CH      = 8,
    parameter int DATA_W      = 12
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [NUM_CH-1:0]         ch_mask,
    input  logic                      uni,
    output logic                      adc_convst,
    output logic                      adc_sclk,
    output logic                      adc_din,
    input  logic                      adc_dout,
    input  logic [$clog2(NUM_CH)-1:0] rd_addr,
    output logic [DATA_W-1:0]         rd_data,
    output logic [NUM_CH-1:0]         ch_valid,
    output logic                      sample_valid,
    output logic [$clog2(NUM_CH)-1:0] sample_ch,
    output logic [DATA_W-1:0]         sample_data,
    output logic                      scan_done,
    output logic                      busy
);

    import adc_ctrl_pkg::*;

    localparam int AW = $clog2(NUM_CH);
    localparam int CW = $clog2(CONV_CYCLES + 1);
    localparam logic [CW-1:0] CONV_LAST = CW'(CONV_CYCLES - 1);

    state_t              state;
    logic [CW-1:0]       cnt;
    logic [AW-1:0]       cur_ch;
    logic [AW-1:0]       prev_ch;
    logic                primed;
    logic                go;
    logic                start;
    logic                done;
    logic [CFG_BITS-1:0] cfg;
    logic [DATA_W-1:0]   data;
    logic [DATA_W-1:0]   regfile [NUM_CH];

    assign go    = enable && (ch_mask != '0);
    assign start = (state == CONV) && (cnt == CONV_LAST);
    assign cfg   = cfg_word(cur_ch, uni);
    assign busy  = (state != IDLE);

    adc_ltc2308_frame #(
        .CLK_DIV (CLK_DIV)
    ) u_frame (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .cfg      (cfg),
        .adc_dout (adc_dout),
        .adc_sclk (adc_sclk),
        .adc_din  (adc_din),
        .data     (data),
        .done     (done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            cur_ch       <= '0;
            prev_ch      <= '0;
            primed       <= 1'b0;
            adc_convst   <= 1'b0;
            ch_valid     <= '0;
            sample_valid <= 1'b0;
            sample_ch    <= '0;
            sample_data  <= '0;
            scan_done    <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            sample_ch    <= '0;
            sample_data  <= '0;
            scan_done    <= 1'b0;
            unique case (state)
                IDLE: if (go) begin
                    state      <= CONV;
                    cnt        <= '0;
                    cur_ch     <= low_ch(ch_mask);
                    primed     <= 1'b0;
                    adc_convst <= 1'b1;
                end
                CONV: if (start) begin
                    state      <= SHIFT;
                    adc_convst <= 1'b0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                SHIFT: if (done) state <= UPDATE;
                UPDATE: begin
                    if (primed) begin
                        ch_valid[prev_ch] <= 1'b1;
                        sample_valid      <= 1'b1;
                        sample_ch         <= prev_ch;
                        sample_data       <= data;
                        scan_done         <= (ch_mask != '0) &&
                                             (prev_ch == high_ch(ch_mask));
                    end
                    primed  <= 1'b1;
                    prev_ch <= cur_ch;
                    cur_ch  <= next_ch(ch_mask, cur_ch);
                    if (go) begin
                        state      <= CONV;
                        cnt        <= '0;
                        adc_convst <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Read sees the pre-write value on a same-cycle hit
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) regfile[i] <= '0;
            rd_data <= '0;
        end else begin
            if (state == UPDATE && primed) regfile[prev_ch] <= data;
            rd_data <= regfile[rd_addr];
        end
    end

endmodule

// File: tb/tb_adc_scan_ctrl.sv
// Bench for adc_scan_ctrl: LTC2308 pin model, sample scoreboard,
// table of scan scenarios plus reset and timing sequences.
module tb_adc_scan_ctrl;

    logic        clk = 1'b0;
    logic        reset, enable, uni;
    logic [7:0]  ch_mask;
    logic        adc_convst, adc_sclk, adc_din;
    logic        dout = 1'b0;
    logic [2:0]  rd_addr;
    logic [11:0] rd_data;
    logic [7:0]  ch_valid;
    logic        sample_valid;
    logic [2:0]  sample_ch;
    logic [11:0] sample_data;
    logic        scan_done, busy;

    always #10 clk = ~clk;

    adc_scan_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .ch_mask      (ch_mask),
        .uni          (uni),
        .adc_convst   (adc_convst),
        .adc_sclk     (adc_sclk),
        .adc_din      (adc_din),
        .adc_dout     (dout),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .ch_valid     (ch_valid),
        .sample_valid (sample_valid),
        .sample_ch    (sample_ch),
        .sample_data  (sample_data),
        .scan_done    (scan_done),
        .busy         (busy)
    );

    typedef struct packed {
        logic [2:0]  ch;
        logic [11:0] data;
        logic        done;
    } smp_t;

    typedef struct packed {
        logic [7:0]  mask;
        logic        uni;
        logic [11:0] v0, v1, v2;
        logic [5:0]  c0, c1, c2;
        logic [7:0]  valid;
    } vec_t;

    int          n_vec = 0;
    int          n_err = 0;
    smp_t        exp_q[$];
    logic [11:0] adc_vals[$];
    logic [5:0]  cfg_log[$];
    logic [11:0] mem_model [8];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int hi_bit(input logic [7:0] m);
        int r = -1;
        for (int i = 0; i < 8; i++) if (m[i]) r = i;
        return r;
    endfunction

    // ADC pin model and scoreboard producer/consumer
    logic        pc, ps, m_primed, have_rise, tail_bad;
    logic [11:0] fval, tx;
    logic [5:0]  cfg;
    logic [2:0]  last_ch;
    int          gap, conv_len, hi_len, lo_len, pulses;

    always @(negedge clk) begin
        smp_t s;
        if (reset) begin
            exp_q.delete();
            for (int i = 0; i < 8; i++) mem_model[i] = '0;
            m_primed = 0; have_rise = 0; pc = 0; ps = 0; dout = 0;
            gap = 0; pulses = 0;
        end else begin
            gap++;
            if (!busy) begin m_primed = 0; have_rise = 0; end
            if (sample_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_sample", 1, 0);
                end else begin
                    s = exp_q.pop_front();
                    chk("sample_ch", sample_ch, s.ch);
                    chk("sample_data", sample_data, s.data);
                    chk("scan_done", scan_done, s.done);
                    mem_model[s.ch] = s.data;
                end
            end
            if (adc_convst && !pc) begin
                if (have_rise) chk("frame_period", gap, 129);
                gap = 0; have_rise = 1; conv_len = 0;
                if (adc_vals.size() > 0) fval = adc_vals.pop_front();
                else fval = 12'($urandom);
                if (m_primed) begin
                    s.ch = last_ch;
                    s.data = fval;
                    s.done = (int'(last_ch) == hi_bit(ch_mask));
                    exp_q.push_back(s);
                end
                m_primed = 1; pulses = 0; tail_bad = 0;
            end
            if (!adc_convst && pc) begin
                chk("convst_len", conv_len, 80);
                tx = fval; dout = tx[11]; lo_len = 0;
            end
            if (adc_sclk && !ps) begin
                chk("sclk_low", lo_len, 2);
                hi_len = 0; pulses++;
                if (pulses <= 6) cfg = {cfg[4:0], adc_din};
                else if (adc_din) tail_bad = 1;
                if (pulses == 6) begin
                    cfg_log.push_back(cfg);
                    last_ch = {cfg[3], cfg[2], cfg[4]};
                end
            end
            if (!adc_sclk && ps) begin
                chk("sclk_high", hi_len, 2);
                lo_len = 0; tx = tx << 1; dout = tx[11];
                if (pulses == 12) chk("din_tail", tail_bad, 0);
            end
            if (adc_convst) conv_len++;
            if (adc_sclk) hi_len++; else lo_len++;
            pc = adc_convst; ps = adc_sclk;
        end
    end

    initial begin
        vec_t tv[5];
        int   t, act;
        tv[0] = '{8'h80, 1'b0, 12'h123, 12'h456, 12'h789,
                  6'h3C, 6'h3C, 6'h3C, 8'h80};
        tv[1] = '{8'h05, 1'b1, 12'h000, 12'hA5C, 12'h3F1,
                  6'h22, 6'h26, 6'h22, 8'h85};
        tv[2] = '{8'h0A, 1'b1, 12'h0F0, 12'hABC, 12'h777,
                  6'h32, 6'h36, 6'h32, 8'h8F};
        tv[3] = '{8'hC1, 1'b0, 12'h111, 12'h222, 12'h333,
                  6'h20, 6'h2C, 6'h3C, 8'hCF};
        tv[4] = '{8'h24, 1'b1, 12'h555, 12'h666, 12'hFFF,
                  6'h26, 6'h3A, 6'h26, 8'hEF};

        reset = 1; enable = 0; ch_mask = 0; uni = 0; rd_addr = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_convst", adc_convst, 0);
        chk("rst_sclk", adc_sclk, 0);
        chk("rst_din", adc_din, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ch_valid", ch_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_sample_valid", sample_valid, 0);
        chk("rst_scan_done", scan_done, 0);
        chk("rst_sample_data", sample_data, 0);
        reset = 0;

        act = 0;
        repeat (200) begin
            @(negedge clk);
            if (adc_sclk || adc_convst || busy) act++;
        end
        chk("idle_quiet", act, 0);

        for (int i = 0; i < 5; i++) begin
            adc_vals.push_back(tv[i].v0);
            adc_vals.push_back(tv[i].v1);
            adc_vals.push_back(tv[i].v2);
            cfg_log.delete();
            ch_mask = tv[i].mask; uni = tv[i].uni; enable = 1;
            t = 0;
            while (cfg_log.size() < 3 && t < 800) begin
                @(negedge clk); t++;
            end
            enable = 0;
            chk("cfg_wait", cfg_log.size() >= 3, 1);
            if (cfg_log.size() >= 3) begin
                chk("cfg0", cfg_log[0], tv[i].c0);
                chk("cfg1", cfg_log[1], tv[i].c1);
                chk("cfg2", cfg_log[2], tv[i].c2);
            end
            t = 0;
            do begin @(negedge clk); t++; end
            while (!sample_valid && t < 300);
            chk("last_sample_wait", sample_valid, 1);
            chk("busy_after_update", busy, 0);
            repeat (3) @(negedge clk);
            chk("ch_valid", ch_valid, tv[i].valid);
            for (int a = 0; a < 8; a++) begin
                rd_addr = 3'(a);
                @(negedge clk);
                chk("rd_data", rd_data, mem_model[a]);
            end
        end
        chk("scoreboard_empty", exp_q.size(), 0);
        chk("adc_vals_used", adc_vals.size(), 0);

        ch_mask = 8'h05; uni = 1; enable = 1;
        t = 0;
        while (!adc_sclk && t < 300) begin @(negedge clk); t++; end
        chk("reach_shift", adc_sclk, 1);
        reset = 1;
        @(negedge clk);
        chk("mid_rst_sclk", adc_sclk, 0);
        chk("mid_rst_convst", adc_convst, 0);
        chk("mid_rst_ch_valid", ch_valid, 0);
        chk("mid_rst_busy", busy, 0);
        reset = 0; enable = 0; rd_addr = 0;
        @(negedge clk);
        chk("mid_rst_rd_data", rd_data, 0);
        chk("mid_rst_no_sample", sample_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
